// File: rtl/target_controller.sv
// rtl/target_controller.sv - snake food placement sequencer: steps the generator, vets candidates against the body store, tracks score/win
module target_controller #(
    parameter int MAX_LENGTH  = 32,
    parameter int MAX_RETRIES = 15,
    parameter int SCORE_MAX   = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic [7:0] i_head_x,
    input  logic [6:0] i_head_y,
    input  logic [5:0] i_snake_length,
    output logic [4:0] o_seg_addr,
    input  logic [7:0] i_seg_x,
    input  logic [6:0] i_seg_y,
    output logic       o_gen_req,
    input  logic [7:0] i_gen_x,
    input  logic [6:0] i_gen_y,
    output logic [7:0] o_target_x,
    output logic [6:0] o_target_y,
    output logic       o_target_valid,
    output logic       o_grow,
    output logic [3:0] o_score,
    output logic       o_win
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);
    localparam logic [5:0]         LEN_MAX   = 6'(MAX_LENGTH);
    localparam logic [3:0]         SCORE_LIM = 4'(SCORE_MAX);

    typedef enum logic [2:0] {S_REQ, S_CAPTURE, S_SCAN, S_ARMED, S_WON} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cand_x;
    logic [6:0]         r_cand_y;
    logic [5:0]         r_len;
    logic [4:0]         r_idx;
    logic [RETRY_W-1:0] r_retry;
    logic [7:0]         r_target_x;
    logic [6:0]         r_target_y;
    logic               r_valid;
    logic               r_grow;
    logic [3:0]         r_score;
    logic               r_win;

    logic       w_commit;
    logic       w_retry_inc;
    logic       w_eat;
    logic       w_seg_hit;
    logic       w_last;
    logic       w_gen_oob;
    logic       w_can_retry;
    logic [3:0] w_score_inc;
    logic [5:0] w_len_clamp;

    assign w_seg_hit   = (i_seg_x == r_cand_x) && (i_seg_y == r_cand_y);
    assign w_last      = ({1'b0, r_idx} == (r_len - 6'd1));
    assign w_gen_oob   = (i_gen_x > 8'd159) || (i_gen_y > 7'd119);
    assign w_can_retry = (r_retry < RETRY_LIM);
    assign w_score_inc = r_score + 4'd1;
    assign w_len_clamp = (i_snake_length == 6'd0)   ? 6'd1 :
                         (i_snake_length > LEN_MAX) ? LEN_MAX : i_snake_length;

    always_comb begin
        w_next      = r_state;
        w_commit    = 1'b0;
        w_retry_inc = 1'b0;
        w_eat       = 1'b0;
        case (r_state)
            S_REQ: w_next = S_CAPTURE;
            S_CAPTURE: begin
                // out-of-range candidates are never force-committed
                if (w_gen_oob) begin
                    w_retry_inc = w_can_retry;
                    w_next      = S_REQ;
                end else begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_seg_hit && w_can_retry) begin
                    w_retry_inc = 1'b1;
                    w_next      = S_REQ;
                end else if (w_seg_hit || w_last) begin
                    w_commit = 1'b1;
                    w_next   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (i_tick && (i_head_x == r_target_x) && (i_head_y == r_target_y)) begin
                    w_eat  = 1'b1;
                    w_next = (w_score_inc == SCORE_LIM) ? S_WON : S_REQ;
                end
            end
            S_WON:   w_next = S_WON;
            default: w_next = S_CAPTURE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_CAPTURE;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_len      <= 6'd1;
            r_idx      <= '0;
            r_retry    <= '0;
            r_target_x <= '0;
            r_target_y <= '0;
            r_valid    <= 1'b0;
            r_grow     <= 1'b0;
            r_score    <= '0;
            r_win      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_grow  <= w_eat;
            if (r_state == S_CAPTURE) begin
                r_cand_x <= i_gen_x;
                r_cand_y <= i_gen_y;
                r_len    <= w_len_clamp;
                r_idx    <= '0;
            end
            if (r_state == S_SCAN) begin
                r_idx <= r_idx + 5'd1;
            end
            if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_commit) begin
                r_target_x <= r_cand_x;
                r_target_y <= r_cand_y;
                r_valid    <= 1'b1;
                r_retry    <= '0;
            end
            if (w_eat) begin
                r_valid <= 1'b0;
                r_score <= w_score_inc;
                r_win   <= (w_score_inc == SCORE_LIM);
            end
        end
    end

    // body store has one cycle of read latency, so the address runs one index ahead of the compare
    assign o_seg_addr     = (r_state == S_SCAN) ? (r_idx + 5'd1) : 5'd0;
    assign o_gen_req      = (r_state == S_REQ);
    assign o_target_x     = r_target_x;
    assign o_target_y     = r_target_y;
    assign o_target_valid = r_valid;
    assign o_grow         = r_grow;
    assign o_score        = r_score;
    assign o_win          = r_win;

endmodule

// File: tb/tb_target_controller.sv
// tb/tb_target_controller.sv - randomized self-checking bench for target_controller
module tb_target_controller;

    localparam int RETRIES = 15;

    logic       clk = 1'b0;
    logic       i_reset, i_tick;
    logic [7:0] i_head_x;
    logic [6:0] i_head_y;
    logic [5:0] i_snake_length;
    logic [4:0] o_seg_addr;
    logic [7:0] seg_x, gen_x, o_target_x;
    logic [6:0] seg_y, gen_y, o_target_y;
    logic       o_gen_req, o_target_valid, o_grow, o_win;
    logic [3:0] o_score;

    int bx[32], by[32];
    int gx[256], gy[256];
    int gidx;
    int n_cmp = 0, n_fail = 0;
    int m_g, m_tx, m_ty;

    target_controller dut (
        .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick),
        .i_head_x(i_head_x), .i_head_y(i_head_y), .i_snake_length(i_snake_length),
        .o_seg_addr(o_seg_addr), .i_seg_x(seg_x), .i_seg_y(seg_y),
        .o_gen_req(o_gen_req), .i_gen_x(gen_x), .i_gen_y(gen_y),
        .o_target_x(o_target_x), .o_target_y(o_target_y), .o_target_valid(o_target_valid),
        .o_grow(o_grow), .o_score(o_score), .o_win(o_win)
    );

    always #5 clk = ~clk;

    // body store and target generator environment models
    always @(posedge clk) begin
        seg_x <= 8'(bx[o_seg_addr]);
        seg_y <= 7'(by[o_seg_addr]);
        if (i_reset) gidx <= 0;
        else if (o_gen_req) gidx <= (gidx + 1) % 256;
    end
    assign gen_x = 8'(gx[gidx]);
    assign gen_y = 7'(gy[gidx]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        return (len == 0) ? 1 : (len > 32) ? 32 : len;
    endfunction

    // walks the candidate stream: returns accepted target, cycles from first CAPTURE to valid, and retries
    task automatic model_place(input int g0, input int n, output int ex, output int ey,
                               output int cyc, output int reqs, output int gend);
        int r, acc, g, hit;
        bit done;
        r = 0; acc = 0; g = g0; reqs = 0; done = 0; ex = 0; ey = 0; cyc = 0;
        for (int step = 0; step < 200 && !done; step++) begin
            int cx, cy;
            cx = gx[g % 256]; cy = gy[g % 256];
            if (cx > 159 || cy > 119) begin
                reqs++; if (r < RETRIES) r++; acc += 2; g++;
            end else begin
                hit = -1;
                for (int j = 0; j < n; j++)
                    if (hit < 0 && bx[j] == cx && by[j] == cy) hit = j;
                if (hit < 0) begin
                    ex = cx; ey = cy; cyc = acc + n + 1; done = 1;
                end else if (r < RETRIES) begin
                    r++; reqs++; acc += hit + 3; g++;
                end else begin
                    ex = cx; ey = cy; cyc = acc + hit + 2; done = 1;
                end
            end
        end
        gend = g % 256;
    endtask

    // called on the negedge of the CAPTURE cycle
    task automatic place();
        int ex, ey, ecyc, ereqs, gend, c, reqs;
        bit seen, prev, dbl;
        model_place(m_g, clamp_len(int'(i_snake_length)), ex, ey, ecyc, ereqs, gend);
        c = 0; reqs = 0; seen = 0; dbl = 0; prev = o_gen_req;
        while (!seen && c < 3000) begin
            @(negedge clk);
            c++;
            if (o_gen_req) begin
                reqs++;
                if (prev) dbl = 1;
            end
            prev = o_gen_req;
            if (o_target_valid) seen = 1;
        end
        check("place_seen", 32'(seen), 1);
        check("place_latency", c, ecyc);
        check("gen_req_pulses", reqs, ereqs);
        check("gen_req_back_to_back", 32'(dbl), 0);
        check("target_x", o_target_x, ex);
        check("target_y", o_target_y, ey);
        m_g = gend; m_tx = ex; m_ty = ey;
    endtask

    task automatic eat(input int k);
        i_head_x = 8'(m_tx); i_head_y = 7'(m_ty); i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        check("eat_grow", o_grow, 1);
        check("eat_valid", o_target_valid, 0);
        check("eat_score", o_score, k);
        check("eat_win", o_win, (k == 10) ? 1 : 0);
        check("eat_gen_req", o_gen_req, (k < 10) ? 1 : 0);
        @(negedge clk);
        check("grow_single", o_grow, 0);
        if (k < 10) m_g = (m_g + 1) % 256;
    endtask

    task automatic check_reset_outputs();
        check("rst_seg_addr", o_seg_addr, 0);
        check("rst_gen_req", o_gen_req, 0);
        check("rst_target_x", o_target_x, 0);
        check("rst_target_y", o_target_y, 0);
        check("rst_valid", o_target_valid, 0);
        check("rst_grow", o_grow, 0);
        check("rst_score", o_score, 0);
        check("rst_win", o_win, 0);
    endtask

    task automatic random_body();
        for (int j = 0; j < 32; j++) begin
            bx[j] = int'($urandom_range(0, 159));
            by[j] = int'($urandom_range(0, 119));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            if (i >= 20 && ($urandom % 6) == 0) begin
                gx[i] = ($urandom % 2) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 159));
                gy[i] = (gx[i] > 159) ? int'($urandom_range(0, 127)) : int'($urandom_range(120, 127));
            end else begin
                gx[i] = int'($urandom_range(0, 159));
                gy[i] = int'($urandom_range(0, 119));
            end
        end
        gx[0] = 80; gy[0] = 60;
        random_body();
        bx[0] = 10; by[0] = 10; bx[1] = 11; by[1] = 10; bx[2] = 12; by[2] = 10;
        i_reset = 1'b1; i_tick = 1'b0; i_head_x = '0; i_head_y = '0; i_snake_length = 6'd3;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        i_reset = 1'b0;
        m_g = 0;
        place();

        i_head_x = 8'd0; i_head_y = 7'd0; i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        check("miss_valid", o_target_valid, 1);
        check("miss_grow", o_grow, 0);
        check("miss_score", o_score, 0);
        check("miss_gen_req", o_gen_req, 0);

        for (int k = 1; k <= 10; k++) begin
            int g;
            g = (m_g + 1) % 256;
            if (k == 1) begin
                bx[1] = gx[g]; by[1] = gy[g];
            end else if (k == 2) begin
                i_snake_length = 6'd32;
                for (int j = 0; j < 32; j++) begin
                    bx[j] = gx[(g + j) % 256]; by[j] = gy[(g + j) % 256];
                end
            end else begin
                i_snake_length = 6'($urandom_range(0, 40));
                random_body();
                if ($urandom % 2) begin
                    int j;
                    j = int'($urandom_range(0, 31));
                    bx[j] = gx[g]; by[j] = gy[g];
                end
            end
            eat(k);
            if (k < 10) place();
        end

        repeat (3) begin
            i_head_x = 8'(m_tx); i_head_y = 7'(m_ty); i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
            check("won_gen_req", o_gen_req, 0);
            check("won_win", o_win, 1);
            check("won_score", o_score, 10);
            check("won_grow", o_grow, 0);
            check("won_valid", o_target_valid, 0);
        end

        i_snake_length = 6'd32;
        random_body();
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        repeat (8) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        i_reset = 1'b0;
        m_g = 0;
        place();
        eat(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/target_controller.md
# target_controller

Sequencing controller for the snake game's target (food) generator. It decides when the generator is stepped and vets each candidate target against the snake body, scanning the body-position store one segment per cycle. It publishes the accepted target to the VGA/collision logic and owns the score and win condition. It sits between the snake-movement logic, the body-position memory and the target generator.

## Interface
- MAX_LENGTH, 32, maximum body segments addressable (SEG_ADDR range 0..MAX_LENGTH-1)
- MAX_RETRIES, 15, rejected candidates tolerated before a forced commit
- SCORE_MAX, 10, score at which the game is won
- CLK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- TICK  in  1  one-cycle strobe: snake head has moved this cycle
- HEAD_X  in  8  head column (0-159)
- HEAD_Y  in  7  head row (0-119)
- SNAKE_LENGTH  in  6  current segment count including head
- SEG_ADDR  out  5  body-store read index
- SEG_X  in  8  segment column; valid one cycle after SEG_ADDR
- SEG_Y  in  7  segment row; valid one cycle after SEG_ADDR
- GEN_REQ  out  1  one-cycle step pulse to the generator's TARGET_REACHED
- GEN_X  in  8  generator column output (registered in generator)
- GEN_Y  in  7  generator row output
- TARGET_X  out  8  accepted target column
- TARGET_Y  out  7  accepted target row
- TARGET_VALID  out  1  target displayed and collectable
- GROW  out  1  one-cycle pulse: snake must lengthen by one
- SCORE  out  4  targets eaten, saturates at SCORE_MAX
- WIN  out  1  level, set when SCORE reaches SCORE_MAX

## Operation
- States: REQ, CAPTURE, SCAN, ARMED, WON.
- Reset values:
  - All outputs 0: SEG_ADDR, GEN_REQ, TARGET_X/Y, TARGET_VALID, GROW, SCORE, WIN.
  - Internal state: retry count 0; the next state is CAPTURE.
  - The generator resets on the same RESET, so the first candidate is 80,60.
- REQ: GEN_REQ=1 for exactly one cycle, then CAPTURE.
- CAPTURE:
  - Latch GEN_X/GEN_Y into the candidate register.
  - Latch N = SNAKE_LENGTH, clamped to 1..MAX_LENGTH.
  - Drive SEG_ADDR=0, then SCAN.
- SCAN, cycle j (j=0..N-1):
  - Compare SEG_X/SEG_Y (data for index j) against the candidate; drive SEG_ADDR=j+1.
  - On match: reject.
  - Reaching j=N-1 with no match: commit.
- Out-of-range candidate (X>159 or Y>119): rejected in CAPTURE, with no scan.
- Reject:
  - If retry count < MAX_RETRIES: increment it and go to REQ.
  - Otherwise, for an in-range candidate only: force commit.
  - An out-of-range candidate always retries.
- Commit: TARGET_X/Y <= candidate, TARGET_VALID <= 1, retry count <= 0, then ARMED.
- ARMED:
  - TICK with HEAD_X==TARGET_X and HEAD_Y==TARGET_Y: TARGET_VALID<=0, GROW pulses, SCORE increments.
  - Then go to WON if the new SCORE == SCORE_MAX, else REQ.
  - TICK without a match: no effect.
- TICK is ignored in every state except ARMED.
- WON: TARGET_VALID=0, WIN=1, GEN_REQ never asserted. Only RESET exits.
- RESET in any state (mid-scan, during a GEN_REQ pulse) returns to reset values the next cycle. No partial commit.

## Timing
- Clean placement:
  - GEN_REQ high in cycle t; CAPTURE in t+1.
  - SCAN occupies t+2..t+1+N.
  - TARGET_VALID high from t+2+N.
- After reset: CAPTURE is the first cycle after RESET deasserts; TARGET_VALID rises N+1 cycles later.
- A collision at segment j aborts the scan: GEN_REQ is asserted in the cycle after SCAN cycle j.
- Eat event: with the TICK at cycle e, GROW=1 and TARGET_VALID=0 in cycle e+1. SCORE is updated in e+1. GEN_REQ is in e+1 (or WIN=1 in e+1).
- Worst-case placement latency: (MAX_RETRIES+1)*(MAX_LENGTH+2) cycles. TICK period must exceed this.
- GEN_REQ is never high for two consecutive cycles.

## Test plan
- Reset, SNAKE_LENGTH=3, body at (10,10),(11,10),(12,10) -> TARGET=(80,60), TARGET_VALID rises on the 4th cycle after RESET falls, GEN_REQ never pulsed.
- Body segment 1 placed at (80,60) -> reject after 2 SCAN cycles, one GEN_REQ, new candidate scanned. TARGET = the generator's next value. Retry count then cleared.
- Head at TARGET with TICK -> next cycle GROW=1 (single cycle), SCORE=1, TARGET_VALID=0, GEN_REQ=1. A TICK with a non-matching head changes nothing.
- Body model collides with every candidate, MAX_RETRIES=15 -> exactly 15 GEN_REQ pulses, then forced commit of the 16th candidate.
- Eat 10 targets -> WIN=1 and SCORE=10. Further TICKs on the old target position change nothing; GEN_REQ stays 0.
- RESET asserted mid-SCAN -> all outputs reset next cycle, then normal placement restarts from the 80,60 candidate.
